// File: rtl/order_serializer.sv
// order_serializer: frames order messages into an SOF-led MSB-first byte stream; ORDER_SERIALIZER_CHECKSUM_EN appends an XOR checksum byte
module order_serializer #(
  parameter logic [7:0] SOF_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  msg_type,
  input  logic [63:0] msg_order_id,
  input  logic [31:0] msg_price,
  input  logic [31:0] msg_volume,
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] cycle_cnt,
  output logic [31:0] t_accept,
  output logic [31:0] t_egress,
  output logic [15:0] frames_sent,
  output logic        busy
);
`ifdef ORDER_SERIALIZER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
  logic [7:0] csum;
`else
  typedef enum logic {IDLE, SEND} state_t;
`endif
  state_t state, state_nx;
  logic [135:0] frame;
  logic [4:0] byte_idx, idx_nx;
  logic [7:0] next_byte;
  logic accept, hs, last;
  assign accept = msg_valid && msg_ready;
  assign hs = tx_valid && tx_ready;
  assign last = byte_idx == 5'd17;
  assign idx_nx = byte_idx + 5'd1;
  assign next_byte = 8'(frame >> (8'd136 - {idx_nx, 3'b000}));
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
`ifdef ORDER_SERIALIZER_CHECKSUM_EN
    state_nx = state == IDLE ? (accept ? SEND : IDLE) :
               state == SEND ? (hs && last ? CSUM : SEND) :
               (hs ? IDLE : CSUM);
`else
    state_nx = state == IDLE ? (accept ? SEND : IDLE) : (hs && last ? IDLE : SEND);
`endif
  end
  always_comb begin
    msg_ready = state == IDLE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data <= '0;
      byte_idx <= '0;
      t_accept <= '0;
      t_egress <= '0;
      frames_sent <= '0;
      frame <= '0;
`ifdef ORDER_SERIALIZER_CHECKSUM_EN
      csum <= '0;
`endif
    end else if (accept) begin
      frame <= {msg_type, msg_order_id, msg_price, msg_volume};
      byte_idx <= '0;
      t_accept <= cycle_cnt;
      tx_valid <= 1'b1;
      tx_data <= SOF_BYTE;
`ifdef ORDER_SERIALIZER_CHECKSUM_EN
      csum <= '0;
`endif
    end else if (hs) begin
`ifdef ORDER_SERIALIZER_CHECKSUM_EN
      csum <= csum ^ tx_data;
      if (state == CSUM) begin
        tx_valid <= 1'b0;
        t_egress <= cycle_cnt;
        frames_sent <= frames_sent + 16'd1;
      end else if (last) begin
        byte_idx <= 5'd18;
        tx_data <= csum ^ tx_data;
      end else begin
        byte_idx <= idx_nx;
        tx_data <= next_byte;
      end
`else
      if (last) begin
        tx_valid <= 1'b0;
        t_egress <= cycle_cnt;
        frames_sent <= frames_sent + 16'd1;
      end else begin
        byte_idx <= idx_nx;
        tx_data <= next_byte;
      end
`endif
    end
  end
endmodule

// File: tb/tb_order_serializer.sv
// tb_order_serializer: randomized self-checking bench for order_serializer against a byte-list reference model
module tb_order_serializer;
  localparam logic [7:0] SOF = 8'hA5;
`ifdef ORDER_SERIALIZER_CHECKSUM_EN
  localparam int FLEN = 19;
`else
  localparam int FLEN = 18;
`endif
  localparam logic [135:0] REF_MSG = {8'h42, 64'h0102030405060708, 32'h0000_1388, 32'h0000_0064};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] msg_type = '0;
  logic [63:0] msg_order_id = '0;
  logic [31:0] msg_price = '0;
  logic [31:0] msg_volume = '0;
  logic msg_valid = 1'b0;
  logic msg_ready;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b0;
  logic [31:0] cycle_cnt;
  logic [31:0] t_accept, t_egress;
  logic [15:0] frames_sent;
  logic busy;
  logic [7:0] got [$];
  int passed = 0;
  int total = 0;
  int stall_bad = 0;
  int ncyc = 0;
  logic [15:0] exp_frames = '0;
  logic [31:0] acc_cnt = '0;
  logic [31:0] last_cnt = '0;

  order_serializer #(.SOF_BYTE(SOF)) dut (
    .clk(clk), .rst(rst), .msg_type(msg_type), .msg_order_id(msg_order_id),
    .msg_price(msg_price), .msg_volume(msg_volume), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cycle_cnt(cycle_cnt), .t_accept(t_accept), .t_egress(t_egress),
    .frames_sent(frames_sent), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= rst ? 32'hFFFF_FFF0 : cycle_cnt + 32'd1;

  function automatic logic [7:0] model_byte(input logic [135:0] f, input int i);
    logic [7:0] x = SOF;
    if (i == 0) return SOF;
    if (i < 18) return 8'(f >> (8 * (17 - i)));
    for (int k = 1; k < 18; k++) x = x ^ 8'(f >> (8 * (17 - k)));
    return x;
  endfunction

  task automatic offer(input logic [135:0] f, output bit tout);
    {msg_type, msg_order_id, msg_price, msg_volume} = f;
    msg_valid = 1'b1;
    tout = 1'b1;
    for (int c = 0; c < 200 && tout; c++) begin
      if (msg_ready) begin
        tout = 1'b0;
        acc_cnt = cycle_cnt;
      end
      @(negedge clk);
    end
  endtask

  task automatic collect(input int mode, input int nbytes, output bit tout);
    logic [7:0] prev = 8'h00;
    bit stalled = 1'b0;
    got.delete();
    stall_bad = 0;
    ncyc = 0;
    for (int c = 0; c < 1000 && got.size() < nbytes; c++) begin
      tx_ready = mode == 0 ? 1'b1 : mode == 1 ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      if (stalled && (!tx_valid || tx_data !== prev)) stall_bad++;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        last_cnt = cycle_cnt;
      end
      stalled = tx_valid && !tx_ready;
      prev = tx_data;
      ncyc++;
      @(negedge clk);
    end
    tout = got.size() < nbytes;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else passed++;
    total++; if (t_accept !== 32'h0) $display("FAIL reset_t_accept: got %h want 0", t_accept); else passed++;
    total++; if (t_egress !== 32'h0) $display("FAIL reset_t_egress: got %h want 0", t_egress); else passed++;
    total++; if (frames_sent !== 16'h0) $display("FAIL reset_frames: got %h want 0", frames_sent); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (msg_ready !== 1'b1) $display("FAIL reset_msg_ready: got %b want 1", msg_ready); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit to;
    offer(REF_MSG, to);
    msg_valid = 1'b0;
    total++; if (to) $display("FAIL basic_accept: got timeout want accept"); else passed++;
    collect(0, FLEN, to);
    exp_frames = exp_frames + 16'd1;
    total++; if (to) $display("FAIL basic_timeout: got %0d bytes want %0d", got.size(), FLEN); else passed++;
    total++; if (ncyc != FLEN) $display("FAIL basic_cycles: got %0d want %0d", ncyc, FLEN); else passed++;
    for (int i = 0; i < FLEN; i++) begin
      total++;
      if (i >= got.size() || got[i] !== model_byte(REF_MSG, i)) $display("FAIL basic_byte%0d: got %h want %h", i, got[i], model_byte(REF_MSG, i));
      else passed++;
    end
    total++; if (frames_sent !== exp_frames) $display("FAIL basic_frames: got %h want %h", frames_sent, exp_frames); else passed++;
    total++; if (t_accept !== acc_cnt) $display("FAIL basic_t_accept: got %h want %h", t_accept, acc_cnt); else passed++;
    total++; if (t_egress !== last_cnt) $display("FAIL basic_t_egress: got %h want %h", t_egress, last_cnt); else passed++;
    total++; if (t_egress - t_accept !== 32'(FLEN)) $display("FAIL basic_latency: got %0d want %0d", t_egress - t_accept, FLEN); else passed++;
    total++; if (tx_valid !== 1'b0 || msg_ready !== 1'b1) $display("FAIL basic_idle: got valid=%b ready=%b want 0/1", tx_valid, msg_ready); else passed++;
  endtask

  task automatic test_toggle;
    bit to;
    offer(REF_MSG, to);
    msg_valid = 1'b0;
    collect(1, FLEN, to);
    exp_frames = exp_frames + 16'd1;
    total++; if (to) $display("FAIL toggle_timeout: got %0d bytes want %0d", got.size(), FLEN); else passed++;
    total++; if (stall_bad != 0) $display("FAIL toggle_stable: got %0d unstable cycles want 0", stall_bad); else passed++;
    for (int i = 0; i < FLEN; i++) begin
      total++;
      if (i >= got.size() || got[i] !== model_byte(REF_MSG, i)) $display("FAIL toggle_byte%0d: got %h want %h", i, got[i], model_byte(REF_MSG, i));
      else passed++;
    end
    total++; if (frames_sent !== exp_frames) $display("FAIL toggle_frames: got %h want %h", frames_sent, exp_frames); else passed++;
  endtask

  task automatic test_back_to_back;
    bit to;
    logic [135:0] f1 = {8'($urandom), $urandom, $urandom, $urandom, $urandom};
    logic [135:0] f2 = {8'($urandom), $urandom, $urandom, $urandom, $urandom};
    logic [31:0] acc2;
    offer(f1, to);
    {msg_type, msg_order_id, msg_price, msg_volume} = f2;
    collect(0, FLEN, to);
    exp_frames = exp_frames + 16'd1;
    total++; if (to) $display("FAIL b2b_timeout1: got %0d bytes want %0d", got.size(), FLEN); else passed++;
    for (int i = 0; i < FLEN; i++) begin
      total++;
      if (i >= got.size() || got[i] !== model_byte(f1, i)) $display("FAIL b2b_f1_byte%0d: got %h want %h", i, got[i], model_byte(f1, i));
      else passed++;
    end
    total++; if (msg_ready !== 1'b1) $display("FAIL b2b_bubble: got msg_ready=%b want 1", msg_ready); else passed++;
    acc2 = cycle_cnt;
    @(negedge clk);
    msg_valid = 1'b0;
    total++; if (tx_valid !== 1'b1 || tx_data !== SOF || busy !== 1'b1) $display("FAIL b2b_accept: got valid=%b data=%h busy=%b want 1/%h/1", tx_valid, tx_data, busy, SOF); else passed++;
    total++; if (t_accept !== acc2) $display("FAIL b2b_t_accept: got %h want %h", t_accept, acc2); else passed++;
    collect(2, FLEN, to);
    exp_frames = exp_frames + 16'd1;
    total++; if (to) $display("FAIL b2b_timeout2: got %0d bytes want %0d", got.size(), FLEN); else passed++;
    for (int i = 0; i < FLEN; i++) begin
      total++;
      if (i >= got.size() || got[i] !== model_byte(f2, i)) $display("FAIL b2b_f2_byte%0d: got %h want %h", i, got[i], model_byte(f2, i));
      else passed++;
    end
    total++; if (frames_sent !== exp_frames) $display("FAIL b2b_frames: got %h want %h", frames_sent, exp_frames); else passed++;
  endtask

  task automatic test_reset_mid;
    bit to;
    logic [135:0] f = {8'($urandom), $urandom, $urandom, $urandom, $urandom};
    offer(f, to);
    msg_valid = 1'b0;
    collect(0, 6, to);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_frames = '0;
    total++; if (tx_valid !== 1'b0) $display("FAIL rmid_tx_valid: got %b want 0", tx_valid); else passed++;
    total++; if (frames_sent !== 16'h0) $display("FAIL rmid_frames: got %h want 0", frames_sent); else passed++;
    total++; if (msg_ready !== 1'b1) $display("FAIL rmid_msg_ready: got %b want 1", msg_ready); else passed++;
    tx_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (tx_valid !== 1'b0) $display("FAIL rmid_quiet%0d: got %b want 0", c, tx_valid); else passed++;
    end
    f = {8'($urandom), $urandom, $urandom, $urandom, $urandom};
    offer(f, to);
    msg_valid = 1'b0;
    collect(2, FLEN, to);
    exp_frames = exp_frames + 16'd1;
    total++; if (to) $display("FAIL rmid_timeout: got %0d bytes want %0d", got.size(), FLEN); else passed++;
    for (int i = 0; i < FLEN; i++) begin
      total++;
      if (i >= got.size() || got[i] !== model_byte(f, i)) $display("FAIL rmid_byte%0d: got %h want %h", i, got[i], model_byte(f, i));
      else passed++;
    end
    total++; if (frames_sent !== exp_frames) $display("FAIL rmid_frames_after: got %h want %h", frames_sent, exp_frames); else passed++;
  endtask

  task automatic test_random;
    bit to;
    logic [135:0] f;
    for (int n = 0; n < 8; n++) begin
      f = {8'($urandom), $urandom, $urandom, $urandom, $urandom};
      offer(f, to);
      msg_valid = 1'b0;
      {msg_type, msg_order_id, msg_price, msg_volume} = {8'($urandom), $urandom, $urandom, $urandom, $urandom};
      collect(int'($urandom_range(0, 2)), FLEN, to);
      exp_frames = exp_frames + 16'd1;
      total++; if (to) $display("FAIL rand%0d_timeout: got %0d bytes want %0d", n, got.size(), FLEN); else passed++;
      total++; if (stall_bad != 0) $display("FAIL rand%0d_stable: got %0d unstable cycles want 0", n, stall_bad); else passed++;
      for (int i = 0; i < FLEN; i++) begin
        total++;
        if (i >= got.size() || got[i] !== model_byte(f, i)) $display("FAIL rand%0d_byte%0d: got %h want %h", n, i, got[i], model_byte(f, i));
        else passed++;
      end
      total++; if (frames_sent !== exp_frames) $display("FAIL rand%0d_frames: got %h want %h", n, frames_sent, exp_frames); else passed++;
      total++; if (t_accept !== acc_cnt) $display("FAIL rand%0d_t_accept: got %h want %h", n, t_accept, acc_cnt); else passed++;
      total++; if (t_egress !== last_cnt) $display("FAIL rand%0d_t_egress: got %h want %h", n, t_egress, last_cnt); else passed++;
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end
  endtask

  task automatic test_wrap;
    bit to;
    logic [135:0] f = {8'($urandom), $urandom, $urandom, $urandom, $urandom};
    force dut.frames_sent = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent;
    exp_frames = 16'hFFFF;
    offer(f, to);
    msg_valid = 1'b0;
    collect(0, FLEN, to);
    exp_frames = exp_frames + 16'd1;
    total++; if (to) $display("FAIL wrap_timeout: got %0d bytes want %0d", got.size(), FLEN); else passed++;
    total++; if (frames_sent !== exp_frames) $display("FAIL wrap_frames: got %h want %h", frames_sent, exp_frames); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
